// File: rtl/bp_update_sched_if.sv
// Branch-resolution / predictor-update bus for bp_update_sched.
// master = resolution sources + predictor + controller side, slave = scheduler.
interface bp_update_sched_if #(
    parameter int VLEN = 64
);
    logic            flush_i;

    logic            req0_valid_i;
    logic            req0_ready_o;
    logic [VLEN-1:0] req0_pc_i;
    logic [VLEN-1:0] req0_target_i;
    logic            req0_taken_i;
    logic            req0_mispredict_i;
    logic [2:0]      req0_cf_i;

    logic            req1_valid_i;
    logic            req1_ready_o;
    logic [VLEN-1:0] req1_pc_i;
    logic [VLEN-1:0] req1_target_i;
    logic            req1_taken_i;
    logic            req1_mispredict_i;
    logic [2:0]      req1_cf_i;

    logic            upd_valid_o;
    logic            upd_ready_i;
    logic [VLEN-1:0] upd_pc_o;
    logic [VLEN-1:0] upd_target_o;
    logic            upd_taken_o;
    logic            upd_mispredict_o;
    logic [2:0]      upd_cf_o;

    logic            redirect_valid_o;
    logic [VLEN-1:0] redirect_target_o;
    logic            squash_o;
    logic [31:0]     perf_mispredict_o;
    logic [31:0]     perf_dropped_o;

    modport slave (
        input  flush_i,
        input  req0_valid_i, req0_pc_i, req0_target_i, req0_taken_i, req0_mispredict_i, req0_cf_i,
        output req0_ready_o,
        input  req1_valid_i, req1_pc_i, req1_target_i, req1_taken_i, req1_mispredict_i, req1_cf_i,
        output req1_ready_o,
        output upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o, upd_mispredict_o, upd_cf_o,
        input  upd_ready_i,
        output redirect_valid_o, redirect_target_o, squash_o,
        output perf_mispredict_o, perf_dropped_o
    );

    modport master (
        output flush_i,
        output req0_valid_i, req0_pc_i, req0_target_i, req0_taken_i, req0_mispredict_i, req0_cf_i,
        input  req0_ready_o,
        output req1_valid_i, req1_pc_i, req1_target_i, req1_taken_i, req1_mispredict_i, req1_cf_i,
        input  req1_ready_o,
        input  upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o, upd_mispredict_o, upd_cf_o,
        output upd_ready_i,
        input  redirect_valid_o, redirect_target_o, squash_o,
        input  perf_mispredict_o, perf_dropped_o
    );
endinterface

// File: rtl/bp_update_sched.sv
// Age-ordered predictor-update FIFO with mispredict redirect and wrong-path squash.
// Optional saturating perf counters under `BP_UPDATE_PERF_EN.
module bp_update_sched #(
    parameter int VLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    bp_update_sched_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        logic            taken;
        logic            mispredict;
        logic [2:0]      cf;
    } entry_t;

    typedef enum logic {RUN, SQUASH} state_t;

    state_t            state;
    logic              active;
    logic [CW-1:0]     count;
    logic [AW-1:0]     wptr, rptr;
    entry_t            mem [DEPTH];
    entry_t [1:0]      req;
    entry_t            head;

    logic              run, rdy0, rdy1, acc0, acc1;
    logic              mp0_hit, push0, push1, go_sq, pop;
    logic [1:0]        n_push;
    logic [CW-1:0]     space;

    assign req[0] = '{pc: bus.req0_pc_i, target: bus.req0_target_i, taken: bus.req0_taken_i,
                      mispredict: bus.req0_mispredict_i, cf: bus.req0_cf_i};
    assign req[1] = '{pc: bus.req1_pc_i, target: bus.req1_target_i, taken: bus.req1_taken_i,
                      mispredict: bus.req1_mispredict_i, cf: bus.req1_cf_i};

    // Readiness uses the pre-dequeue count; active keeps readys low while in reset.
    assign run   = (state == RUN);
    assign space = CW'(DEPTH) - count;
    assign rdy0  = active & (~run | (space >= CW'(1)));
    assign rdy1  = active & (~run | (space >= CW'(2)));

    always_comb begin
        acc0    = bus.req0_valid_i & rdy0;
        acc1    = bus.req1_valid_i & rdy1;
        mp0_hit = run & acc0 & req[0].mispredict;
        push0   = run & acc0 & ((req[0].cf != 3'd0) | req[0].mispredict);
        push1   = run & acc1 & ~mp0_hit & ((req[1].cf != 3'd0) | req[1].mispredict);
        go_sq   = mp0_hit | (push1 & req[1].mispredict);
        pop     = (count != '0) & bus.upd_ready_i;
        n_push  = {1'b0, push0} + {1'b0, push1};
    end

    always_ff @(posedge clk_i) begin
        if (push0) mem[wptr] <= req[0];
        if (push1) mem[wptr + AW'(push0)] <= req[1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            count <= count + CW'(n_push) - CW'(pop);
            wptr  <= wptr + AW'(n_push);
            rptr  <= rptr + AW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                 <= RUN;
            active                <= 1'b0;
            bus.redirect_valid_o  <= 1'b0;
            bus.redirect_target_o <= '0;
        end else begin
            active               <= 1'b1;
            bus.redirect_valid_o <= go_sq;
            if (go_sq) bus.redirect_target_o <= mp0_hit ? req[0].target : req[1].target;
            case (state)
                RUN:     if (go_sq)       state <= SQUASH;
                SQUASH:  if (bus.flush_i) state <= RUN;
                default:                  state <= RUN;
            endcase
        end
    end

    assign head                 = (count != '0) ? mem[rptr] : '0;
    assign bus.req0_ready_o     = rdy0;
    assign bus.req1_ready_o     = rdy1;
    assign bus.upd_valid_o      = (count != '0);
    assign bus.upd_pc_o         = head.pc;
    assign bus.upd_target_o     = head.target;
    assign bus.upd_taken_o      = head.taken;
    assign bus.upd_mispredict_o = head.mispredict;
    assign bus.upd_cf_o         = head.cf;
    assign bus.squash_o         = ~run;

`ifdef BP_UPDATE_PERF_EN
    logic [31:0] perf_mp, perf_dr;
    logic [1:0]  n_drop;
    logic        n_mp;
    logic [32:0] mp_sum, dr_sum;

    // Squash-state drops count regardless of cf; req1 lost to an older mispredict counts too.
    assign n_mp   = (push0 & req[0].mispredict) | (push1 & req[1].mispredict);
    assign n_drop = run ? {1'b0, acc1 & mp0_hit} : ({1'b0, acc0} + {1'b0, acc1});
    assign mp_sum = {1'b0, perf_mp} + 33'(n_mp);
    assign dr_sum = {1'b0, perf_dr} + 33'(n_drop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_mp <= '0;
            perf_dr <= '0;
        end else begin
            perf_mp <= mp_sum[32] ? '1 : mp_sum[31:0];
            perf_dr <= dr_sum[32] ? '1 : dr_sum[31:0];
        end
    end

    assign bus.perf_mispredict_o = perf_mp;
    assign bus.perf_dropped_o    = perf_dr;
`else
    assign bus.perf_mispredict_o = '0;
    assign bus.perf_dropped_o    = '0;
`endif
endmodule

// File: tb/tb_bp_update_sched.sv
// Directed table-driven bench for bp_update_sched (VLEN=64, DEPTH=4).
module tb_bp_update_sched;
    typedef struct packed {
        logic        v;
        logic [2:0]  cf;
        logic        mp;
        logic        tk;
        logic [63:0] pc;
        logic [63:0] tg;
    } rq_t;

    typedef struct {
        rq_t         r0, r1;
        logic        urdy, fl;
        logic        er0, er1, euv;
        rq_t         eh;
        logic        erv;
        logic [63:0] ertg;
        logic        esq;
    } vec_t;

    localparam int NV = 36;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   row = -1;
    vec_t vt [NV];

    always #5 clk = ~clk;

    bp_update_sched_if #(.VLEN(64)) bif ();

    bp_update_sched #(.VLEN(64), .DEPTH(4)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bif)
    );

    function automatic rq_t rq(input logic [2:0] cf, input logic mp, input logic tk,
                               input logic [63:0] pc, input logic [63:0] tg);
        rq_t r;
        r = '{v: 1'b1, cf: cf, mp: mp, tk: tk, pc: pc, tg: tg};
        return r;
    endfunction

    function automatic rq_t br(input logic [63:0] pc);
        return rq(3'd1, 1'b0, 1'b1, pc, pc + 64'h40);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d act=%h exp=%h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input rq_t r0, input rq_t r1, input logic urdy, input logic fl);
        bif.req0_valid_i = r0.v;  bif.req0_cf_i = r0.cf;  bif.req0_mispredict_i = r0.mp;
        bif.req0_taken_i = r0.tk; bif.req0_pc_i = r0.pc;  bif.req0_target_i = r0.tg;
        bif.req1_valid_i = r1.v;  bif.req1_cf_i = r1.cf;  bif.req1_mispredict_i = r1.mp;
        bif.req1_taken_i = r1.tk; bif.req1_pc_i = r1.pc;  bif.req1_target_i = r1.tg;
        bif.upd_ready_i  = urdy;  bif.flush_i   = fl;
    endtask

    initial begin
        rq_t n, m, j, lp, nc0, nc1;
        n   = '0;
        m   = rq(3'd1, 1'b1, 1'b1, 64'h2ff0, 64'h3000);
        j   = rq(3'd2, 1'b1, 1'b1, 64'h7004, 64'h8000);
        lp  = rq(3'd1, 1'b0, 1'b0, 64'h2000, 64'h2040);
        nc0 = rq(3'd0, 1'b0, 1'b0, 64'h6ff0, 64'h6ff8);
        nc1 = rq(3'd0, 1'b0, 1'b0, 64'h6ff4, 64'h6ffc);
        //          r0           r1           urdy fl  r0 r1 uv head         rv rtg       sq
        vt[0]  = '{br(64'h1000), n,            1, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[1]  = '{n,            n,            1, 0,  1, 1, 1, br(64'h1000), 0, 64'h0,    0};
        vt[2]  = '{n,            n,            0, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[3]  = '{lp,           br(64'h2004), 0, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[4]  = '{n,            n,            0, 0,  1, 1, 1, lp,           0, 64'h0,    0};
        vt[5]  = '{n,            n,            1, 0,  1, 1, 1, lp,           0, 64'h0,    0};
        vt[6]  = '{n,            n,            1, 0,  1, 1, 1, br(64'h2004), 0, 64'h0,    0};
        vt[7]  = '{m,            br(64'h2ff4), 0, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[8]  = '{br(64'h4000), n,            0, 0,  1, 1, 1, m,            1, 64'h3000, 1};
        vt[9]  = '{br(64'h4004), n,            0, 1,  1, 1, 1, m,            0, 64'h0,    1};
        vt[10] = '{n,            n,            1, 0,  1, 1, 1, m,            0, 64'h0,    0};
        vt[11] = '{br(64'h5000), br(64'h5004), 0, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[12] = '{br(64'h5008), n,            0, 0,  1, 1, 1, br(64'h5000), 0, 64'h0,    0};
        vt[13] = '{br(64'h500c), br(64'h5010), 0, 0,  1, 0, 1, br(64'h5000), 0, 64'h0,    0};
        vt[14] = '{n,            br(64'h5010), 1, 0,  0, 0, 1, br(64'h5000), 0, 64'h0,    0};
        vt[15] = '{br(64'h5010), n,            0, 0,  1, 0, 1, br(64'h5004), 0, 64'h0,    0};
        vt[16] = '{n,            n,            1, 0,  0, 0, 1, br(64'h5004), 0, 64'h0,    0};
        vt[17] = '{n,            n,            1, 0,  1, 0, 1, br(64'h5008), 0, 64'h0,    0};
        vt[18] = '{n,            n,            1, 0,  1, 1, 1, br(64'h500c), 0, 64'h0,    0};
        vt[19] = '{n,            n,            1, 0,  1, 1, 1, br(64'h5010), 0, 64'h0,    0};
        vt[20] = '{n,            n,            0, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[21] = '{br(64'h6000), nc0,          1, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[22] = '{br(64'h6004), n,            1, 0,  1, 1, 1, br(64'h6000), 0, 64'h0,    0};
        vt[23] = '{nc1,          br(64'h6008), 1, 0,  1, 1, 1, br(64'h6004), 0, 64'h0,    0};
        vt[24] = '{br(64'h600c), br(64'h6010), 1, 0,  1, 1, 1, br(64'h6008), 0, 64'h0,    0};
        vt[25] = '{br(64'h6014), n,            1, 0,  1, 1, 1, br(64'h600c), 0, 64'h0,    0};
        vt[26] = '{n,            n,            1, 0,  1, 1, 1, br(64'h6010), 0, 64'h0,    0};
        vt[27] = '{n,            n,            1, 0,  1, 1, 1, br(64'h6014), 0, 64'h0,    0};
        vt[28] = '{n,            n,            0, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[29] = '{br(64'h7000), j,            0, 0,  1, 1, 0, n,            0, 64'h0,    0};
        vt[30] = '{n,            n,            0, 0,  1, 1, 1, br(64'h7000), 1, 64'h8000, 1};
        vt[31] = '{n,            n,            0, 1,  1, 1, 1, br(64'h7000), 0, 64'h0,    1};
        vt[32] = '{n,            n,            0, 0,  1, 1, 1, br(64'h7000), 0, 64'h0,    0};
        vt[33] = '{n,            n,            1, 1,  1, 1, 1, br(64'h7000), 0, 64'h0,    0};
        vt[34] = '{n,            n,            1, 0,  1, 1, 1, j,            0, 64'h0,    0};
        vt[35] = '{n,            n,            0, 0,  1, 1, 0, n,            0, 64'h0,    0};

        // reset state
        drive(n, n, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_req0_ready", 64'(bif.req0_ready_o), 64'h0);
        chk("rst_req1_ready", 64'(bif.req1_ready_o), 64'h0);
        chk("rst_upd_valid",  64'(bif.upd_valid_o), 64'h0);
        chk("rst_upd_pc",     bif.upd_pc_o, 64'h0);
        chk("rst_redirect",   64'(bif.redirect_valid_o), 64'h0);
        chk("rst_redir_tgt",  bif.redirect_target_o, 64'h0);
        chk("rst_squash",     64'(bif.squash_o), 64'h0);
        chk("rst_perf_mp",    64'(bif.perf_mispredict_o), 64'h0);
        chk("rst_perf_dr",    64'(bif.perf_dropped_o), 64'h0);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            row = i;
            drive(vt[i].r0, vt[i].r1, vt[i].urdy, vt[i].fl);
            #1;
            chk("req0_ready", 64'(bif.req0_ready_o), 64'(vt[i].er0));
            chk("req1_ready", 64'(bif.req1_ready_o), 64'(vt[i].er1));
            chk("upd_valid",  64'(bif.upd_valid_o), 64'(vt[i].euv));
            chk("redirect",   64'(bif.redirect_valid_o), 64'(vt[i].erv));
            chk("squash",     64'(bif.squash_o), 64'(vt[i].esq));
            if (vt[i].euv) begin
                chk("upd_pc",     bif.upd_pc_o, vt[i].eh.pc);
                chk("upd_target", bif.upd_target_o, vt[i].eh.tg);
                chk("upd_taken",  64'(bif.upd_taken_o), 64'(vt[i].eh.tk));
                chk("upd_mispr",  64'(bif.upd_mispredict_o), 64'(vt[i].eh.mp));
                chk("upd_cf",     64'(bif.upd_cf_o), 64'(vt[i].eh.cf));
            end
            if (vt[i].erv) chk("redirect_tgt", bif.redirect_target_o, vt[i].ertg);
        end

        row = NV;
`ifdef BP_UPDATE_PERF_EN
        chk("perf_mispredict", 64'(bif.perf_mispredict_o), 64'd2);
        chk("perf_dropped",    64'(bif.perf_dropped_o), 64'd3);
`else
        chk("perf_mispredict_off", 64'(bif.perf_mispredict_o), 64'd0);
        chk("perf_dropped_off",    64'(bif.perf_dropped_o), 64'd0);
`endif

        // reset in the middle of a redirect with a stored entry
        @(negedge clk);
        row = NV + 1;
        drive(rq(3'd1, 1'b1, 1'b1, 64'h9000, 64'h9100), n, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(n, n, 1'b0, 1'b0);
        chk("mid_redirect", 64'(bif.redirect_valid_o), 64'h1);
        chk("mid_redir_tgt", bif.redirect_target_o, 64'h9100);
        chk("mid_upd_valid", 64'(bif.upd_valid_o), 64'h1);
        rst_ni = 1'b0;
        #1;
        chk("mrst_redirect",  64'(bif.redirect_valid_o), 64'h0);
        chk("mrst_upd_valid", 64'(bif.upd_valid_o), 64'h0);
        chk("mrst_squash",    64'(bif.squash_o), 64'h0);
        chk("mrst_perf_mp",   64'(bif.perf_mispredict_o), 64'h0);
        chk("mrst_perf_dr",   64'(bif.perf_dropped_o), 64'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_ready0", 64'(bif.req0_ready_o), 64'h1);
        chk("post_rst_ready1", 64'(bif.req1_ready_o), 64'h1);
        chk("post_rst_empty",  64'(bif.upd_valid_o), 64'h0);
        chk("post_rst_redir",  64'(bif.redirect_valid_o), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
